// File: rtl/ysyx_25040111_lsu.sv
// Load/store and writeback stage: latches one executed instruction, runs the
// data-memory transaction when needed, then retires it with a finish pulse.
module ysyx_25040111_lsu #(
  parameter int TIMEOUT = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        men,
  input  logic [4:0]  ard,
  input  logic [31:0] rd,
  input  logic        gen,
  input  logic [11:0] acsr,
  input  logic [31:0] csr,
  input  logic        sen,
  input  logic        write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [1:0]  mask,
  input  logic        rsign,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_write,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_wdata,
  output logic [3:0]  mem_req_wstrb,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  input  logic        mem_rsp_err,
  output logic        gpr_wen,
  output logic [4:0]  gpr_waddr,
  output logic [31:0] gpr_wdata,
  output logic        csr_wen,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        finish,
  output logic [4:0]  frd,
  output logic        err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WB} state_t;

  state_t        state_q;
  logic          men_q, gen_q, sen_q, write_q, rsign_q, err_q;
  logic [4:0]    ard_q;
  logic [31:0]   rd_q, csr_q, addr_q, wdata_q, rdata_q;
  logic [11:0]   acsr_q;
  logic [1:0]    mask_q;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          misaligned;
  logic [3:0]    strb_base;
  logic [31:0]   rsh, load_data;

  assign misaligned = ((mask == 2'b10) && addr[0]) ||
                      ((mask == 2'b11) && (addr[1:0] != 2'b00));
  assign cnt_d      = cnt_q + CW'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      men_q   <= 1'b0;
      gen_q   <= 1'b0;
      sen_q   <= 1'b0;
      write_q <= 1'b0;
      rsign_q <= 1'b0;
      ard_q   <= '0;
      rd_q    <= '0;
      csr_q   <= '0;
      acsr_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          men_q   <= men;
          ard_q   <= ard;
          rd_q    <= rd;
          gen_q   <= gen;
          acsr_q  <= acsr;
          csr_q   <= csr;
          sen_q   <= sen;
          write_q <= write;
          addr_q  <= addr;
          wdata_q <= wdata;
          mask_q  <= mask;
          rsign_q <= rsign;
          rdata_q <= '0;
          err_q   <= men & misaligned;
          state_q <= (men && !misaligned) ? REQ : WB;
        end
        REQ: if (mem_req_ready) begin
          cnt_q   <= '0;
          state_q <= WAIT;
        end
        WAIT: begin
          if (mem_rsp_valid) begin
            rdata_q <= mem_rsp_data;
            err_q   <= mem_rsp_err;
            state_q <= WB;
          end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
            err_q   <= 1'b1;
            state_q <= WB;
          end else begin
            cnt_q   <= cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    strb_base = 4'b0000;
    case (mask_q)
      2'b01:   strb_base = 4'b0001;
      2'b10:   strb_base = 4'b0011;
      2'b11:   strb_base = 4'b1111;
      default: strb_base = 4'b0000;
    endcase
  end

  assign rsh = rdata_q >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_data = rsh;
    case (mask_q)
      2'b01:   load_data = {{24{rsign_q & rsh[7]}}, rsh[7:0]};
      2'b10:   load_data = {{16{rsign_q & rsh[15]}}, rsh[15:0]};
      default: load_data = rsh;
    endcase
  end

  assign in_ready      = (state_q == IDLE);
  assign mem_req_valid = (state_q == REQ);
  assign mem_req_write = write_q;
  assign mem_req_addr  = {addr_q[31:2], 2'b00};
  assign mem_req_wdata = wdata_q << {addr_q[1:0], 3'b000};
  assign mem_req_wstrb = write_q ? (strb_base << addr_q[1:0]) : 4'b0000;

  assign finish    = (state_q == WB);
  assign frd       = ard_q;
  assign err       = finish & err_q;
  // A faulted access or any store never touches the GPR file.
  assign gpr_wen   = finish & gen_q & (ard_q != 5'd0) & ~err_q & ~(men_q & write_q);
  assign gpr_waddr = ard_q;
  assign gpr_wdata = (men_q & ~write_q) ? load_data : rd_q;
  assign csr_wen   = finish & sen_q;
  assign csr_waddr = acsr_q;
  assign csr_wdata = csr_q;

endmodule

// File: tb/tb_ysyx_25040111_lsu.sv
// Directed bench for the LSU stage, built with a short timeout so the abort path is reachable.
module tb_ysyx_25040111_lsu;
  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, men, gen, sen, write, rsign;
  logic [4:0]  ard, gpr_waddr, frd;
  logic [31:0] rd, csr, addr, wdata, gpr_wdata, csr_wdata;
  logic [11:0] acsr, csr_waddr;
  logic [1:0]  mask;
  logic        mem_req_valid, mem_req_ready, mem_req_write;
  logic [31:0] mem_req_addr, mem_req_wdata, mem_rsp_data;
  logic [3:0]  mem_req_wstrb;
  logic        mem_rsp_valid, mem_rsp_err;
  logic        gpr_wen, csr_wen, finish, err;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  ysyx_25040111_lsu #(.TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .men(men), .ard(ard), .rd(rd), .gen(gen), .acsr(acsr), .csr(csr), .sen(sen),
    .write(write), .addr(addr), .wdata(wdata), .mask(mask), .rsign(rsign),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
    .gpr_wen(gpr_wen), .gpr_waddr(gpr_waddr), .gpr_wdata(gpr_wdata),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .finish(finish), .frd(frd), .err(err)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_in();
    in_valid = 0; men = 0; ard = 0; rd = 0; gen = 0; acsr = 0; csr = 0; sen = 0;
    write = 0; addr = 0; wdata = 0; mask = 0; rsign = 0;
  endtask

  initial begin
    clear_in();
    reset = 1; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_data = 0; mem_rsp_err = 0;
    step(); step();
    reset = 0;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_req_valid", 32'(mem_req_valid), 0);
    chk("rst_finish", 32'(finish), 0);
    chk("rst_gpr_wen", 32'(gpr_wen), 0);
    chk("rst_csr_wen", 32'(csr_wen), 0);
    chk("rst_err", 32'(err), 0);

    // non-memory instruction
    in_valid = 1; ard = 5; rd = 32'h1234; gen = 1;
    chk("nm_accept_ready", 32'(in_ready), 1);
    step(); clear_in();
    chk("nm_finish", 32'(finish), 1);
    chk("nm_gpr_wen", 32'(gpr_wen), 1);
    chk("nm_gpr_waddr", 32'(gpr_waddr), 5);
    chk("nm_gpr_wdata", gpr_wdata, 32'h1234);
    chk("nm_frd", 32'(frd), 5);
    chk("nm_err", 32'(err), 0);
    chk("nm_busy", 32'(in_ready), 0);
    step();
    chk("nm_ready_again", 32'(in_ready), 1);
    chk("nm_finish_off", 32'(finish), 0);

    // signed byte load from top lane
    in_valid = 1; men = 1; write = 0; addr = 32'h8000_0003; mask = 2'b01; rsign = 1;
    gen = 1; ard = 7; mem_req_ready = 1;
    step(); clear_in();
    chk("lb_req_valid", 32'(mem_req_valid), 1);
    chk("lb_req_addr", mem_req_addr, 32'h8000_0000);
    chk("lb_req_wstrb", 32'(mem_req_wstrb), 0);
    chk("lb_req_write", 32'(mem_req_write), 0);
    step();
    mem_req_ready = 0; mem_rsp_valid = 1; mem_rsp_data = 32'h80FF_0000;
    chk("lb_wait_novalid", 32'(mem_req_valid), 0);
    chk("lb_wait_nofinish", 32'(finish), 0);
    step(); mem_rsp_valid = 0;
    chk("lb_finish", 32'(finish), 1);
    chk("lb_gpr_wen", 32'(gpr_wen), 1);
    chk("lb_gpr_wdata", gpr_wdata, 32'hFFFF_FF80);
    chk("lb_frd", 32'(frd), 7);
    step();

    // half store with back-pressure; input data changes after accept
    in_valid = 1; men = 1; write = 1; addr = 32'h102; wdata = 32'hABCD; mask = 2'b10;
    gen = 1; ard = 3; mem_req_ready = 0;
    step(); clear_in(); wdata = 32'h5555_5555;
    for (int i = 0; i < 4; i++) begin
      chk("sh_req_valid", 32'(mem_req_valid), 1);
      chk("sh_req_wstrb", 32'(mem_req_wstrb), 32'hC);
      chk("sh_req_wdata", mem_req_wdata, 32'hABCD_0000);
      chk("sh_req_write", 32'(mem_req_write), 1);
      chk("sh_req_addr", mem_req_addr, 32'h100);
      if (i == 3) mem_req_ready = 1;
      step();
    end
    mem_req_ready = 0;
    chk("sh_wait_novalid", 32'(mem_req_valid), 0);
    mem_rsp_valid = 1; mem_rsp_data = 32'hDEAD_BEEF;
    step(); mem_rsp_valid = 0;
    chk("sh_finish", 32'(finish), 1);
    chk("sh_gpr_wen", 32'(gpr_wen), 0);
    chk("sh_err", 32'(err), 0);
    step();

    // misaligned word load
    in_valid = 1; men = 1; write = 0; addr = 32'h101; mask = 2'b11; gen = 1; ard = 4;
    step(); clear_in();
    chk("mis_req_valid", 32'(mem_req_valid), 0);
    chk("mis_finish", 32'(finish), 1);
    chk("mis_err", 32'(err), 1);
    chk("mis_gpr_wen", 32'(gpr_wen), 0);
    chk("mis_frd", 32'(frd), 4);
    step();

    // bus error response
    in_valid = 1; men = 1; write = 0; addr = 32'h200; mask = 2'b11; gen = 1; ard = 9;
    mem_req_ready = 1;
    step(); clear_in();
    step(); mem_req_ready = 0;
    mem_rsp_valid = 1; mem_rsp_err = 1; mem_rsp_data = 32'h1111_2222;
    step(); mem_rsp_valid = 0; mem_rsp_err = 0;
    chk("be_finish", 32'(finish), 1);
    chk("be_err", 32'(err), 1);
    chk("be_gpr_wen", 32'(gpr_wen), 0);
    step();

    // timeout after four silent WAIT cycles
    in_valid = 1; men = 1; write = 0; addr = 32'h300; mask = 2'b11; gen = 1; ard = 10;
    mem_req_ready = 1;
    step(); clear_in();
    step(); mem_req_ready = 0;
    for (int i = 0; i < 4; i++) begin
      chk("to_wait_nofinish", 32'(finish), 0);
      chk("to_wait_noready", 32'(in_ready), 0);
      step();
    end
    chk("to_finish", 32'(finish), 1);
    chk("to_err", 32'(err), 1);
    chk("to_gpr_wen", 32'(gpr_wen), 0);
    step();
    chk("to_idle", 32'(in_ready), 1);

    // CSR write with x0 destination
    in_valid = 1; sen = 1; acsr = 12'h341; csr = 32'h8000_0010; gen = 1; ard = 0; rd = 32'h77;
    step(); clear_in();
    chk("csr_wen", 32'(csr_wen), 1);
    chk("csr_waddr", 32'(csr_waddr), 32'h341);
    chk("csr_wdata", csr_wdata, 32'h8000_0010);
    chk("csr_gpr_wen", 32'(gpr_wen), 0);
    chk("csr_finish", 32'(finish), 1);
    chk("csr_frd", 32'(frd), 0);
    step();
    chk("csr_wen_off", 32'(csr_wen), 0);

    // reset while waiting, then a stray response
    in_valid = 1; men = 1; write = 0; addr = 32'h400; mask = 2'b11; gen = 1; ard = 11;
    mem_req_ready = 1;
    step(); clear_in();
    step(); mem_req_ready = 0;
    reset = 1;
    step(); reset = 0;
    chk("rw_reset_finish", 32'(finish), 0);
    chk("rw_reset_ready", 32'(in_ready), 1);
    mem_rsp_valid = 1; mem_rsp_data = 32'hCAFE_0000;
    step(); mem_rsp_valid = 0;
    chk("rw_late_finish", 32'(finish), 0);
    chk("rw_late_ready", 32'(in_ready), 1);
    chk("rw_late_gpr_wen", 32'(gpr_wen), 0);
    step();
    chk("rw_still_idle", 32'(in_ready), 1);
    chk("rw_no_finish", 32'(finish), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
